// File: rtl/mem_map_res_ctrl.sv
// mem_map_res_ctrl: Avalon-MM slave that drives NUM_CH per-channel reset outputs.
// Each channel's reset is the OR of a software level bit and a one-shot pulse
// counter of programmable length. Per-channel sticky done flags and busy status
// can be read back.
//
// Ports:
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   address    in   2       word address: 0 LEVEL, 1 PULSE/BUSY, 2 PLEN, 3 DONE
//   writedata  in   32      write data
//   readdata   out  32      read data, registered, valid 1 clk after read accepted
//   write      in   1       write strobe
//   read       in   1       read strobe
//   chipselect in   1       qualifies write/read
//   reset_out  out  NUM_CH  per-channel reset, active-high, registered
module mem_map_res_ctrl #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [NUM_CH-1:0] RST_DEF   = {NUM_CH{1'b1}},
  parameter int unsigned       PULSE_DEF = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              write,
  input  logic              read,
  input  logic              chipselect,
  output logic [NUM_CH-1:0] reset_out
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_PULSE = 2'd1;
  localparam logic [1:0] ADDR_PLEN  = 2'd2;
  localparam logic [1:0] ADDR_DONE  = 2'd3;

  logic [NUM_CH-1:0] lvl_q,       lvl_d;
  logic [CNT_W-1:0]  plen_q,      plen_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] done_q,      done_d;
  logic [DATA_W-1:0] readdata_q,  readdata_d;
  logic [NUM_CH-1:0] reset_out_q, reset_out_d;

  logic              wr_en;
  logic              rd_en;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] set;

  // Fold writedata so bits above NUM_CH/CNT_W are intentionally consumed.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;

  // Register file, pulse counters and sticky done flags.
  always_comb begin
    lvl_d  = lvl_q;
    plen_d = plen_q;
    done_d = done_q;
    busy   = '0;
    trig   = '0;
    clr    = '0;
    set    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (wr_en && address == ADDR_LEVEL) begin
      lvl_d = writedata[NUM_CH-1:0];
    end
    if (wr_en && address == ADDR_PLEN) begin
      plen_d = writedata[CNT_W-1:0];
    end

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      busy[i] = (cnt_q[i] != '0);
      trig[i] = wr_en && (address == ADDR_PULSE) && writedata[i];
      clr[i]  = wr_en && (address == ADDR_DONE)  && writedata[i];
      // A retrigger replaces the running count, so the aborted pulse never reports done.
      if (trig[i]) begin
        cnt_d[i] = plen_q;
      end else if (busy[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        set[i]   = (cnt_q[i] == CNT_W'(1));
      end
      // Set has priority over a same-cycle W1C clear.
      done_d[i] = (done_q[i] & ~clr[i]) | set[i];
    end
  end

  // Output and read-data next state, computed from current register state.
  always_comb begin
    reset_out_d = lvl_q | busy;
    readdata_d  = readdata_q;
    if (rd_en) begin
      unique case (address)
        ADDR_LEVEL: readdata_d = DATA_W'(lvl_q);
        ADDR_PULSE: readdata_d = DATA_W'(busy);
        ADDR_PLEN:  readdata_d = DATA_W'(plen_q);
        ADDR_DONE:  readdata_d = DATA_W'(done_q);
        default:    readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q       <= RST_DEF;
      plen_q      <= CNT_W'(PULSE_DEF);
      done_q      <= '0;
      readdata_q  <= '0;
      reset_out_q <= RST_DEF;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lvl_q       <= lvl_d;
      plen_q      <= plen_d;
      done_q      <= done_d;
      readdata_q  <= readdata_d;
      reset_out_q <= reset_out_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata  = readdata_q;
  assign reset_out = reset_out_q;

endmodule

// File: tb/tb_mem_map_res_ctrl.sv
// Directed testbench for mem_map_res_ctrl (NUM_CH=4, CNT_W=16, defaults).
module tb_mem_map_res_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [3:0]  reset_out;

  int checks   = 0;
  int failures = 0;

  mem_map_res_ctrl #(
    .NUM_CH   (4),
    .CNT_W    (16),
    .RST_DEF  (4'hF),
    .PULSE_DEF(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .write     (write),
    .read      (read),
    .chipselect(chipselect),
    .reset_out (reset_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
    cyc();
    write = 1'b0; chipselect = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1; chipselect = 1'b1;
    cyc();
    read = 1'b0; chipselect = 1'b0;
    d = readdata;
  endtask

  logic [31:0] rd;
  int          hi;

  initial begin
    rst = 1'b1; address = '0; writedata = '0; write = 1'b0; read = 1'b0; chipselect = 1'b0;
    repeat (3) cyc();

    // Reset values.
    check_eq("rst_reset_out", 32'(reset_out), 32'hF);
    check_eq("rst_readdata", readdata, 32'h0);
    rst = 1'b0;
    cyc();
    check_eq("post_rst_reset_out", 32'(reset_out), 32'hF);
    bus_rd(2'd0, rd); check_eq("rst_level", rd, 32'hF);
    bus_rd(2'd2, rd); check_eq("rst_plen", rd, 32'h10);
    bus_rd(2'd3, rd); check_eq("rst_done", rd, 32'h0);
    bus_rd(2'd1, rd); check_eq("rst_busy", rd, 32'h0);

    // Basic 5-clk pulse on ch1, plen truncated to CNT_W bits.
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd2, 32'hABCD_0005);
    cyc();
    check_eq("lvl_clear_out", 32'(reset_out), 32'h0);
    bus_rd(2'd2, rd); check_eq("plen_trunc", rd, 32'h5);
    repeat (3) cyc();
    check_eq("readdata_hold", readdata, 32'h5);
    bus_wr(2'd1, 32'h2);
    hi = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (reset_out[1]) hi++; else break;
    end
    check_eq("pulse5_len", 32'(hi), 32'd5);
    check_eq("pulse5_others", 32'(reset_out), 32'h0);
    bus_rd(2'd3, rd); check_eq("pulse5_done", rd, 32'h2);
    bus_rd(2'd1, rd); check_eq("pulse5_busy", rd, 32'h0);
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd3, rd); check_eq("w1c_done", rd, 32'h0);

    // Retrigger on the edge where ch0 would go 4->3: 5 + 8 = 13 clks high.
    bus_wr(2'd2, 32'h8);
    bus_wr(2'd1, 32'h1);
    hi = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        address = 2'd1; writedata = 32'h1; write = 1'b1; chipselect = 1'b1;
      end else if (c == 3 || c == 8) begin
        address = 2'd3; read = 1'b1; chipselect = 1'b1;
      end
      cyc();
      write = 1'b0; read = 1'b0; chipselect = 1'b0;
      if (c == 3) check_eq("retrig_done_early", readdata, 32'h0);
      if (c == 8) check_eq("retrig_done_mid", readdata, 32'h0);
      if (reset_out[0]) hi++; else break;
    end
    check_eq("retrig_len", 32'(hi), 32'd13);
    bus_rd(2'd3, rd); check_eq("retrig_done_end", rd, 32'h1);
    bus_wr(2'd3, 32'h1);

    // Level and pulse OR-ed on ch2; lvl cleared mid-pulse.
    bus_wr(2'd0, 32'h4);
    bus_wr(2'd2, 32'h6);
    bus_wr(2'd1, 32'h4);
    hi = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) begin
        address = 2'd0; writedata = 32'h0; write = 1'b1; chipselect = 1'b1;
      end
      cyc();
      write = 1'b0; chipselect = 1'b0;
      if (reset_out[2]) hi++; else break;
    end
    check_eq("or_len", 32'(hi), 32'd6);
    check_eq("or_after", 32'(reset_out), 32'h0);
    bus_rd(2'd3, rd); check_eq("or_done", rd, 32'h4);
    bus_wr(2'd3, 32'h4);

    // Done set and W1C clear in the same cycle: set wins.
    bus_wr(2'd2, 32'h3);
    bus_wr(2'd1, 32'h2);
    cyc();
    cyc();
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd3, rd); check_eq("set_beats_clr", rd, 32'h2);
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd3, rd); check_eq("clr_after_set", rd, 32'h0);

    // plen = 0: trigger produces nothing.
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd1, 32'h8);
    cyc();
    check_eq("plen0_out", 32'(reset_out), 32'h0);
    bus_rd(2'd1, rd); check_eq("plen0_busy", rd, 32'h0);
    repeat (3) cyc();
    bus_rd(2'd3, rd); check_eq("plen0_done", rd, 32'h0);

    // rst during a pulse on ch3.
    bus_wr(2'd2, 32'd20);
    bus_wr(2'd1, 32'h8);
    repeat (3) cyc();
    check_eq("pre_rst_pulse", 32'(reset_out), 32'h8);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("midrst_reset_out", 32'(reset_out), 32'hF);
    check_eq("midrst_readdata", readdata, 32'h0);
    bus_rd(2'd1, rd); check_eq("midrst_busy", rd, 32'h0);
    bus_rd(2'd2, rd); check_eq("midrst_plen", rd, 32'h10);
    repeat (25) cyc();
    bus_rd(2'd3, rd); check_eq("midrst_done", rd, 32'h0);
    check_eq("midrst_out_hold", 32'(reset_out), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
